// File: rtl/sar_ctrl_pkg.sv
// Shared definitions for the successive-approximation controller and its comparator stage.
package sar_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sar_state_e;

    localparam int SAR_WIDTH   = 7;
    localparam int SAR_CMP_LAT = 2;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int sar_clog2(input int value);
        int w;
        w = 1;
        while (int'(32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sar_ctrl.sv
// MSB-first successive-approximation loop controller with start/busy/done handshake.
module sar_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int WIDTH   = SAR_WIDTH,
    parameter int CMP_LAT = SAR_CMP_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             trustbit,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = sar_clog2(CMP_LAT + 1);
    localparam int IW = sar_clog2(WIDTH);

    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DAC_INIT   = TRIAL_INIT - ONE;
    localparam logic [CW-1:0]    CNT_LAST   = CW'(CMP_LAT);
    localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] bit_mask_s;
    logic [WIDTH-1:0] lower_mask_s;
    logic [WIDTH-1:0] decided_s;
    logic [WIDTH-1:0] next_trial_s;
    logic             load_s;

    assign bit_mask_s   = ONE << idx_q;
    assign lower_mask_s = ONE << (idx_q - IW'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: trial code, DAC drive, result, wait counter, bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial_q <= '0;
            dac_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            trial_q <= trial_d;
            dac_q   <= dac_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. A start seen on the final decision edge reloads immediately,
    // so held-high start gives back-to-back conversions with busy staying high.
    always_comb begin
        state_d      = state_q;
        trial_d      = trial_q;
        dac_d        = dac_q;
        dout_d       = dout_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        done_d       = 1'b0;
        load_s       = 1'b0;
        if (trustbit) begin
            decided_s = trial_q & ~bit_mask_s;
        end else begin
            decided_s = trial_q;
        end
        next_trial_s = decided_s | lower_mask_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (idx_q != '0) begin
                    trial_d = next_trial_s;
                    dac_d   = next_trial_s - ONE;
                    cnt_d   = '0;
                    idx_d   = idx_q - IW'(1);
                end else begin
                    dout_d = decided_s;
                    done_d = 1'b1;
                    if (start) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            state_d = CONV;
            trial_d = TRIAL_INIT;
            dac_d   = DAC_INIT;
            cnt_d   = '0;
            idx_d   = IDX_TOP;
        end else begin
            load_s = 1'b0;
        end
    end

    // Output decode.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            CONV:    busy = 1'b1;
            IDLE:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    assign dac_code = dac_q;
    assign dout     = dout_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Closed-loop bench: two-stage comparator model around sar_ctrl, scoreboard on done.
module tb_sar_ctrl;

    localparam int W = 7;
    localparam int LAT = 21;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         trustbit;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic [W-1:0] analog1 = '0;
    logic         cmp_q;

    typedef struct {
        int val;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    sar_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .trustbit (trustbit),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stage: compare register then trustbit register.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_q    <= 1'b0;
            trustbit <= 1'b0;
        end else begin
            cmp_q    <= (dac_code >= analog1);
            trustbit <= cmp_q;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("dout", int'(dout), e.val);
                check_val("latency", cyc - e.acc, LAT);
            end
        end
    end

    // One conversion from IDLE; optional dac sequence check and a mid-conversion start pulse.
    task automatic run_conv(input int a, input bit chk_seq, input int pulse_k, input int last_dac);
        int seq[7];
        seq = '{63, 31, 47, 39, 35, 37, 36};
        analog1 = W'(a);
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{val: a, acc: cyc + 1});
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            check_val("busy_high", int'(busy), 1);
            if (chk_seq) check_val("dac_seq", int'(dac_code), seq[k / 3]);
            if (k == pulse_k) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("busy_low", int'(busy), 0);
        if (last_dac >= 0) check_val("last_dac", int'(dac_code), last_dac);
        @(negedge clk);
        check_val("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #12;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_dout", int'(dout), 0);
        check_val("rst_dac", int'(dac_code), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_conv(37, 1'b1, -1, 36);
        run_conv(0, 1'b0, -1, 0);
        run_conv(127, 1'b0, -1, 126);
        for (int a = 0; a < 128; a++) run_conv(a, 1'b0, -1, -1);
        run_conv(64, 1'b0, 4, -1);

        // Start held high: two conversions back to back, busy never drops.
        analog1 = W'(10);
        @(negedge clk);
        start = 1'b1;
        sb.push_back('{val: 10, acc: cyc + 1});
        sb.push_back('{val: 100, acc: cyc + 1 + LAT});
        @(negedge clk);
        for (int k = 0; k < 2 * LAT; k++) begin
            check_val("b2b_busy", int'(busy), 1);
            if (k == LAT) analog1 = W'(100);
            if (k == LAT + 1) start = 1'b0;
            @(negedge clk);
        end
        check_val("b2b_busy_low", int'(busy), 0);
        @(negedge clk);

        // Asynchronous reset mid-conversion.
        analog1 = W'(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", int'(busy), 0);
        check_val("arst_done", int'(done), 0);
        check_val("arst_dout", int'(dout), 0);
        check_val("arst_dac", int'(dac_code), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_val("arst_no_busy", int'(busy), 0);
        run_conv(93, 1'b0, -1, -1);

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
